imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder: the memory side of the fetch-to-imem interface.
//  - Fetch presents a word address every cycle; this block returns the instruction word LATENCY cycles later.
//  - Holds a word-addressed RAM that the loader port writes.
//  - Tracks in-flight reads and drops them on a pipeline flush (taken jump), so stale words never reach decode.
// PARAMETERS
//  DEPTH     1024          number of 32-bit words; power of two, >= 2
//  LATENCY   1             request-to-response cycles; legal range 1..4
//  BASE      32'h0000_0000 byte address of word 0; DEPTH*4-aligned
//  NOP_WORD  32'h0000_0013 word driven when no valid data (addi x0,x0,0)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  req_vld    in   1   fetch request valid this cycle
//  req_addr   in   32  byte address from fetch
//  flush      in   1   kill all in-flight reads (jump taken)
//  rsp_vld    out  1   rsp_dat holds the word for a request LATENCY cycles earlier
//  rsp_dat    out  32  instruction word
//  rsp_addr   out  32  byte address that rsp_dat belongs to
//  ld_en      in   1   loader write strobe
//  ld_addr    in   32  loader byte address
//  ld_dat     in   32  loader write data
//  rsp_err    out  1   access error (IMEM_ERR_EN builds only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: one clock, synchronous, active-high.
//    - rst=1 at an edge: rsp_vld=0, rsp_dat=NOP_WORD, rsp_addr=0, rsp_err=0; all in-flight valid bits cleared.
//    - RAM contents are not reset.
//    - Reset asserted mid-operation discards every outstanding read; nothing surfaces after rst deasserts.
//  - Index: idx = (req_addr - BASE) >> 2, truncated to log2(DEPTH) bits.
//  - Accept: req_vld=1 & flush=0 & rst=0 at edge t accepts the request; no backpressure, one accept per cycle.
//  - Response: an accepted request drives rsp_vld=1, rsp_dat=RAM[idx], rsp_addr=req_addr from edge t+LATENCY.
//    - Back-to-back requests give back-to-back responses in order.
//  - Pipeline structure:
//    - Stage 0 is the registered RAM read.
//    - Stages 1..LATENCY-1 are a shift register of {vld, dat, addr, err}.
//  - Invalid slots: rsp_dat=NOP_WORD whenever rsp_vld=0, so the output is never X.
//  - Flush: flush=1 at edge t clears every in-flight valid bit, including a request presented in the same cycle.
//    - rsp_vld=0 for edges t+1 .. t+LATENCY unless new requests are accepted after t.
//  - Loader write: ld_en=1 writes ld_dat to RAM[(ld_addr-BASE)>>2] at the edge.
//    - ld_addr[1:0] is ignored.
//    - An out-of-range ld_addr is dropped; no write occurs.
//  - Read/write collision (same cycle, same index): the read returns OLD data (read-before-write).
//  - Width rules:
//    - BASE subtraction is 32-bit modulo.
//    - Index wrap: without IMEM_ERR_EN, addresses beyond DEPTH alias modulo DEPTH.
// CONFIGURATION
//  IMEM_ERR_EN defined:
//   - A request is erroneous if req_addr[1:0]!=0 or (req_addr-BASE) >= DEPTH*4.
//   - An erroneous request still produces a response slot at t+LATENCY with rsp_vld=1, rsp_err=1, rsp_dat=NOP_WORD.
//   - The RAM is not read.
//   - rsp_err=0 on every non-error slot; rsp_err is flushed like rsp_vld.
//  IMEM_ERR_EN undefined:
//   - rsp_err is tied 0.
//   - Low address bits are ignored.
//   - Out-of-range addresses alias modulo DEPTH.
// TESTING
//  T1 load/read: load RAM[0..3]=32'hA0..A3 via ld port; req 0x0,0x4,0x8,0xC on consecutive cycles, LATENCY=2
//     -> rsp_vld high for 4 cycles starting 2 edges after the first req; rsp_dat=A0,A1,A2,A3; rsp_addr=0x0..0xC.
//  T2 flush: LATENCY=3; req 0x0,0x4,0x8; assert flush together with the 0x8 req
//     -> no response for any of the three; req 0x10 next cycle -> rsp at +3 with RAM[4].
//  T3 collision: RAM[5]=32'h1111; same cycle ld_en to 0x14 with 32'h2222 and req 0x14
//     -> rsp_dat=32'h1111; a req 0x14 next cycle -> 32'h2222.
//  T4 reset mid-flight: LATENCY=4; req 0x0,0x4; rst=1 one cycle later for 1 cycle
//     -> rsp_vld stays 0, rsp_dat=NOP_WORD through the next 6 cycles; RAM[0] intact.
//  T5 errors (IMEM_ERR_EN): req 0x2 -> rsp_vld=1, rsp_err=1, rsp_dat=32'h13;
//     req DEPTH*4 -> rsp_err=1; without the macro, req DEPTH*4 -> rsp_dat=RAM[0], rsp_err=0.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: word RAM + loader port + LATENCY-deep flushable read pipeline.
// Optional `define IMEM_ERR_EN adds misaligned/out-of-range request detection on rsp_err.
module imem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_vld,
  output logic [31:0] rsp_dat,
  output logic [31:0] rsp_addr,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_dat,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   w_off, w_ld_off;
  logic [AW-1:0] w_idx, w_ld_idx;
  logic          w_ld_ok, w_bad, w_acc, w_rd_en;

  assign w_off    = req_addr - BASE;
  assign w_ld_off = ld_addr - BASE;
  assign w_idx    = w_off[AW+1:2];
  assign w_ld_idx = w_ld_off[AW+1:2];
  assign w_ld_ok  = (w_ld_off >> (AW + 2)) == 32'd0;

`ifdef IMEM_ERR_EN
  assign w_bad = (req_addr[1:0] != 2'b00) || ((w_off >> (AW + 2)) != 32'd0);
`else
  assign w_bad = 1'b0;
`endif

  // Flush and reset both veto the same-cycle request.
  assign w_acc   = req_vld & ~flush;
  assign w_rd_en = w_acc & ~w_bad;

  // Storage: write and read in one block so a same-index collision reads old data.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd;

  always_ff @(posedge clk) begin
    if (ld_en && w_ld_ok) r_mem[w_ld_idx] <= ld_dat;
    if (w_rd_en)          r_rd <= r_mem[w_idx];
  end

  // Control pipeline: stage 0 pairs with the RAM read register.
  logic        r_vld  [LATENCY];
  logic [31:0] r_addr [LATENCY];
  logic        r_err  [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= 32'd0;
        r_err[i]  <= 1'b0;
      end
    end else begin
      r_vld[0]  <= w_acc;
      r_addr[0] <= req_addr;
      r_err[0]  <= w_bad;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1] & ~flush;
        r_addr[i] <= r_addr[i-1];
        r_err[i]  <= r_err[i-1];
      end
    end
  end

  // Data stages carry no reset; the output mux hides them when the slot is invalid.
  logic [31:0] w_dat [LATENCY];
  assign w_dat[0] = r_rd;

  for (genvar k = 1; k < LATENCY; k++) begin : g_stg
    logic [31:0] r_dat;
    always_ff @(posedge clk) r_dat <= w_dat[k-1];
    assign w_dat[k] = r_dat;
  end

  assign rsp_vld  = r_vld[LATENCY-1];
  assign rsp_addr = r_addr[LATENCY-1];
  assign rsp_dat  = (r_vld[LATENCY-1] && !r_err[LATENCY-1]) ? w_dat[LATENCY-1] : NOP_WORD;

`ifdef IMEM_ERR_EN
  assign rsp_err = r_vld[LATENCY-1] & r_err[LATENCY-1];
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: four instances (LATENCY 1..4) share one stimulus stream.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        flush;
  logic        ld_en;
  logic [31:0] ld_addr, ld_dat;

  logic        rv [1:4];
  logic [31:0] rd [1:4];
  logic [31:0] ra [1:4];
  logic        re [1:4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr),
    .flush(flush), .rsp_vld(rv[1]), .rsp_dat(rd[1]), .rsp_addr(ra[1]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_dat(ld_dat), .rsp_err(re[1]));
  imem_responder #(.LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr),
    .flush(flush), .rsp_vld(rv[2]), .rsp_dat(rd[2]), .rsp_addr(ra[2]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_dat(ld_dat), .rsp_err(re[2]));
  imem_responder #(.LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr),
    .flush(flush), .rsp_vld(rv[3]), .rsp_dat(rd[3]), .rsp_addr(ra[3]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_dat(ld_dat), .rsp_err(re[3]));
  imem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr),
    .flush(flush), .rsp_vld(rv[4]), .rsp_dat(rd[4]), .rsp_addr(ra[4]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_dat(ld_dat), .rsp_err(re[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Response check on the instance with latency l; address compared only on valid slots.
  task automatic ck(input string tag, input int l, input logic v, input logic [31:0] d,
                    input logic [31:0] a, input logic e);
    chk($sformatf("%s_L%0d_vld", tag, l), 32'(rv[l]), 32'(v));
    chk($sformatf("%s_L%0d_dat", tag, l), rd[l], d);
    chk($sformatf("%s_L%0d_err", tag, l), 32'(re[l]), 32'(e));
    if (v) chk($sformatf("%s_L%0d_addr", tag, l), ra[l], a);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [31:0] a, input logic f);
    req_vld  = v;
    req_addr = a;
    flush    = f;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 32'd0, 1'b0);
    repeat (n) cyc();
  endtask

  logic [31:0] img [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB4, 32'h1111};
  logic [31:0] t5a [3];
  logic [31:0] t5d [3];
  logic        t5e [3];

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
    drv(1'b0, 32'd0, 1'b0);
    repeat (2) cyc();

    // Reset state
    for (int l = 1; l <= 4; l++) begin
      ck("rst", l, 1'b0, NOP, 32'd0, 1'b0);
      chk($sformatf("rst_L%0d_addr", l), ra[l], 32'd0);
    end
    rst = 1'b0;

    // Load image, then an out-of-range write that must be dropped
    for (int i = 0; i < 6; i++) begin
      ld_en = 1'b1; ld_addr = 32'(4 * i); ld_dat = img[i];
      cyc();
    end
    ld_addr = 32'h0000_1000; ld_dat = 32'hDEAD_BEEF;
    cyc();
    ld_en = 1'b0;
    idle(2);

    // T1: back-to-back reads
    for (int s = 0; s < 7; s++) begin
      drv(s < 4, 32'(4 * s), 1'b0);
      cyc();
      if (s - 1 >= 0 && s - 1 <= 3)
        ck("t1", 2, 1'b1, 32'hA0 + 32'(s - 1), 32'(4 * (s - 1)), 1'b0);
      else
        ck("t1", 2, 1'b0, NOP, 32'd0, 1'b0);
      if (s <= 3)
        ck("t1", 1, 1'b1, 32'hA0 + 32'(s), 32'(4 * s), 1'b0);
      else
        ck("t1", 1, 1'b0, NOP, 32'd0, 1'b0);
    end
    idle(5);

    // T2: flush with the third request kills all three
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: drv(1'b1, 32'h0,  1'b0);
        1: drv(1'b1, 32'h4,  1'b0);
        2: drv(1'b1, 32'h8,  1'b1);
        3: drv(1'b1, 32'h10, 1'b0);
        default: drv(1'b0, 32'h0, 1'b0);
      endcase
      cyc();
      if (s == 5) ck("t2", 3, 1'b1, 32'hB4, 32'h10, 1'b0);
      else        ck("t2", 3, 1'b0, NOP, 32'd0, 1'b0);
    end
    idle(5);

    // T3: read-before-write collision
    drv(1'b1, 32'h14, 1'b0);
    ld_en = 1'b1; ld_addr = 32'h14; ld_dat = 32'h2222;
    cyc();
    ld_en = 1'b0;
    cyc();
    drv(1'b0, 32'h0, 1'b0);
    ck("t3_old", 2, 1'b1, 32'h1111, 32'h14, 1'b0);
    cyc();
    ck("t3_new", 2, 1'b1, 32'h2222, 32'h14, 1'b0);
    cyc();
    ck("t3_end", 2, 1'b0, NOP, 32'd0, 1'b0);
    idle(5);

    // T4: reset mid-flight, with a request offered during reset
    for (int s = 0; s < 9; s++) begin
      rst = (s == 2);
      case (s)
        0: drv(1'b1, 32'h0, 1'b0);
        1: drv(1'b1, 32'h4, 1'b0);
        2: drv(1'b1, 32'h8, 1'b0);
        default: drv(1'b0, 32'h0, 1'b0);
      endcase
      cyc();
      ck("t4", 4, 1'b0, NOP, 32'd0, 1'b0);
    end
    rst = 1'b0;
    drv(1'b1, 32'h0, 1'b0);
    cyc();
    idle(3);
    ck("t4_ram0", 4, 1'b1, 32'hA0, 32'h0, 1'b0);
    idle(5);

    // T5: error detection, or aliasing / low-bit masking in the default build
`ifdef IMEM_ERR_EN
    t5a = '{32'h2, 32'h1000, 32'h4};
    t5d = '{NOP, NOP, 32'hA1};
    t5e = '{1'b1, 1'b1, 1'b0};
`else
    t5a = '{32'h1000, 32'h6, 32'h1008};
    t5d = '{32'hA0, 32'hA1, 32'hA2};
    t5e = '{1'b0, 1'b0, 1'b0};
`endif
    for (int s = 0; s < 5; s++) begin
      if (s < 3) drv(1'b1, t5a[s], 1'b0);
      else       drv(1'b0, 32'h0, 1'b0);
      cyc();
      if (s >= 1 && s <= 3) ck($sformatf("t5_%0d", s - 1), 2, 1'b1, t5d[s-1], t5a[s-1], t5e[s-1]);
      else if (s == 4)      ck("t5_end", 2, 1'b0, NOP, 32'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
